// File: rtl/serial_mod_n_detector_pkg.sv
// Shared types and elaboration helpers for the serial mod-N detector.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package mod_det_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit n_in_range(input int n);
      return (n >= 2) && (n <= 255);
   endfunction

   function automatic bit len_in_range(input int len);
      return (len >= 1) && (len <= 1024);
   endfunction

endpackage

// File: rtl/serial_mod_n_detector_if.sv
// Bit-serial input and result bundle for the serial mod-N detector.
// Latency: none (wiring only).
// Backpressure: none; the source gaps the stream with in_valid.
interface serial_mod_n_detector_if #(
   parameter int RW = 2,
   parameter int CW = 6
);
   logic          in_valid;
   logic          x;
   logic          sof;
   logic          eof;
   logic [RW-1:0] rem;
   logic          divisible;
   logic          busy;
   logic          result_valid;
   logic [RW-1:0] result_rem;
   logic [CW-1:0] bit_count;
   logic          overflow;

   modport master (
      output in_valid, x, sof, eof,
      input  rem, divisible, busy, result_valid, result_rem, bit_count, overflow
   );

   modport slave (
      input  in_valid, x, sof, eof,
      output rem, divisible, busy, result_valid, result_rem, bit_count, overflow
   );
endinterface

// File: rtl/serial_mod_n_detector_step.sv
// Modular adder: sum = (a + b + cin) mod N for a, b < N.
// Latency: combinational.
// Backpressure: not applicable.
module mod_n_step
   import mod_det_pkg::*;
#(
   parameter  int N = 3,
   localparam int W = clog2(N)
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum
);
   localparam logic [W:0] NV = (W+1)'(N);

   logic [W:0] t;

   // a + b + cin < 2N, so one conditional subtract reduces it fully.
   always_comb begin
      t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      sum = (t >= NV) ? W'(t - NV) : t[W-1:0];
   end
endmodule

// File: rtl/serial_mod_n_detector.sv
// Tracks a framed bit-serial number mod N (MSB first; LSB first with MOD_DET_LSB_FIRST_EN).
// Latency: rem/divisible one clock after an accepted bit; result_valid one clock after eof.
// Backpressure: none; in_valid low cycles are gaps that leave all state untouched.
module serial_mod_n_detector
   import mod_det_pkg::*;
#(
   parameter int N       = 3,
   parameter int MAX_LEN = 32
) (
   input logic                    clk,
   input logic                    rst,
   serial_mod_n_detector_if.slave bus
);
   localparam int             RW      = clog2(N);
   localparam int             CW      = clog2(MAX_LEN + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LEN);

   generate
      if (!n_in_range(N)) begin : g_bad_n
         $error("serial_mod_n_detector: N=%0d outside 2..255", N);
      end
      if (!len_in_range(MAX_LEN)) begin : g_bad_len
         $error("serial_mod_n_detector: MAX_LEN=%0d outside 1..1024", MAX_LEN);
      end
   endgenerate

   state_t        state;
   logic [RW-1:0] rem_q;
   logic [RW-1:0] result_rem_q;
   logic [RW-1:0] base;
   logic [RW-1:0] rem_nx;
   logic [CW-1:0] cnt_q;
   logic          divisible_q;
   logic          result_valid_q;
   logic          overflow_q;
   logic          accept;

   // Bits count only when valid and either opening a frame or inside one.
   assign accept = bus.in_valid && (bus.sof || (state == RUN));
   // sof restarts the number, discarding whatever was accumulated.
   assign base   = bus.sof ? '0 : rem_q;

`ifdef MOD_DET_LSB_FIRST_EN
   logic [RW-1:0] w_q;
   logic [RW-1:0] w_cur;
   logic [RW-1:0] w_nx;
   logic [RW-1:0] addend;

   // Weight of the current bit is 2^k mod N, restarting at 1 on sof.
   assign w_cur  = bus.sof ? RW'(1) : w_q;
   assign addend = bus.x ? w_cur : '0;

   mod_n_step #(.N(N)) u_rem_step (
      .a   (base),
      .b   (addend),
      .cin (1'b0),
      .sum (rem_nx)
   );

   mod_n_step #(.N(N)) u_weight_step (
      .a   (w_cur),
      .b   (w_cur),
      .cin (1'b0),
      .sum (w_nx)
   );

   // Advance the bit weight on every accepted bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_q <= RW'(1);
      end else if (accept) begin
         w_q <= w_nx;
      end
   end
`else
   // MSB first: rem_next = (2*base + x) mod N, x entering as the carry-in.
   mod_n_step #(.N(N)) u_rem_step (
      .a   (base),
      .b   (base),
      .cin (bus.x),
      .sum (rem_nx)
   );
`endif

   // Frame FSM with all observable outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         rem_q          <= '0;
         divisible_q    <= 1'b1;
         result_valid_q <= 1'b0;
         result_rem_q   <= '0;
         cnt_q          <= '0;
         overflow_q     <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (accept) begin
            rem_q       <= rem_nx;
            divisible_q <= (rem_nx == '0);
            if (bus.sof) begin
               cnt_q      <= CW'(1);
               overflow_q <= 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               overflow_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            if (bus.eof) begin
               state          <= IDLE;
               result_valid_q <= 1'b1;
               result_rem_q   <= rem_nx;
            end else begin
               state <= RUN;
            end
         end
      end
   end

   assign bus.rem          = rem_q;
   assign bus.divisible    = divisible_q;
   assign bus.busy         = (state == RUN);
   assign bus.result_valid = result_valid_q;
   assign bus.result_rem   = result_rem_q;
   assign bus.bit_count    = cnt_q;
   assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_serial_mod_n_detector.sv
// Drives one random bit stream into three detectors (N=3/32, N=5/32, N=7/8) and scores them.
// Latency: expectations are queued per accepted bit and checked the cycle after.
// Backpressure: none; gaps are inserted with in_valid low.
module tb_serial_mod_n_detector;
   import mod_det_pkg::*;

   localparam int ND = 3;

   logic clk;
   logic rst;
   logic in_valid;
   logic x;
   logic sof;
   logic eof;

   serial_mod_n_detector_if #(.RW(clog2(3)), .CW(clog2(33))) ifc0 ();
   serial_mod_n_detector_if #(.RW(clog2(5)), .CW(clog2(33))) ifc1 ();
   serial_mod_n_detector_if #(.RW(clog2(7)), .CW(clog2(9)))  ifc2 ();

   assign ifc0.in_valid = in_valid;
   assign ifc0.x        = x;
   assign ifc0.sof      = sof;
   assign ifc0.eof      = eof;
   assign ifc1.in_valid = in_valid;
   assign ifc1.x        = x;
   assign ifc1.sof      = sof;
   assign ifc1.eof      = eof;
   assign ifc2.in_valid = in_valid;
   assign ifc2.x        = x;
   assign ifc2.sof      = sof;
   assign ifc2.eof      = eof;

   serial_mod_n_detector #(.N(3), .MAX_LEN(32)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
   serial_mod_n_detector #(.N(5), .MAX_LEN(32)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
   serial_mod_n_detector #(.N(7), .MAX_LEN(8))  dut2 (.clk(clk), .rst(rst), .bus(ifc2));

   logic [7:0]  o_rem  [ND];
   logic [7:0]  o_rres [ND];
   logic [15:0] o_bc   [ND];
   logic        o_div  [ND];
   logic        o_busy [ND];
   logic        o_rv   [ND];
   logic        o_ov   [ND];

   assign o_rem[0]  = 8'(ifc0.rem);
   assign o_rem[1]  = 8'(ifc1.rem);
   assign o_rem[2]  = 8'(ifc2.rem);
   assign o_rres[0] = 8'(ifc0.result_rem);
   assign o_rres[1] = 8'(ifc1.result_rem);
   assign o_rres[2] = 8'(ifc2.result_rem);
   assign o_bc[0]   = 16'(ifc0.bit_count);
   assign o_bc[1]   = 16'(ifc1.bit_count);
   assign o_bc[2]   = 16'(ifc2.bit_count);
   assign o_div[0]  = ifc0.divisible;
   assign o_div[1]  = ifc1.divisible;
   assign o_div[2]  = ifc2.divisible;
   assign o_busy[0] = ifc0.busy;
   assign o_busy[1] = ifc1.busy;
   assign o_busy[2] = ifc2.busy;
   assign o_rv[0]   = ifc0.result_valid;
   assign o_rv[1]   = ifc1.result_valid;
   assign o_rv[2]   = ifc2.result_valid;
   assign o_ov[0]   = ifc0.overflow;
   assign o_ov[1]   = ifc1.overflow;
   assign o_ov[2]   = ifc2.overflow;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected state of every DUT after one accepted bit.
   typedef struct packed {
      logic [ND-1:0][7:0]  rem;
      logic [ND-1:0][15:0] bc;
      logic [ND-1:0]       ov;
      logic                busy;
      logic                rv;
   } bexp_t;

   // Observed completed-frame results.
   typedef struct packed {
      logic [ND-1:0][7:0]  rem;
      logic [ND-1:0][15:0] bc;
      logic [ND-1:0]       ov;
   } rx_t;

   int    ns [ND] = '{3, 5, 7};
   int    ml [ND] = '{32, 32, 8};

   bexp_t bq [$];
   rx_t   rxq [$];
   int    exp_res [ND];
   int    checks   = 0;
   int    failures = 0;

   // Reference model: the frame as an integer plus a raw bit count.
   bit     in_frame;
   longint fval;
   int     fk;
   bit     ovm [ND];
   logic   stim_acc;
   logic   acc_d;
   bexp_t  mon_e;
   rx_t    mon_r;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_d(input string nm, input int d, input longint act, input longint req);
      chk($sformatf("%s[n=%0d]", nm, ns[d]), act, req);
   endtask

   // One clock of stimulus; accepted bits push their expected outcome.
   task automatic send_bit(input bit v, input bit xb, input bit s, input bit e);
      bexp_t ent;
      bit    acc;
      in_valid = v;
      x        = xb;
      sof      = s;
      eof      = e;
      acc      = v && (s || in_frame);
      stim_acc = acc;
      if (acc) begin
         if (s) begin
            fval = 0;
            fk   = 0;
            for (int d = 0; d < ND; d++) ovm[d] = 1'b0;
         end
         for (int d = 0; d < ND; d++) if (fk >= ml[d]) ovm[d] = 1'b1;
`ifdef MOD_DET_LSB_FIRST_EN
         fval = fval + (longint'(xb) << fk);
`else
         fval = fval * 2 + longint'(xb);
`endif
         fk++;
         in_frame = !e;
         ent      = '0;
         for (int d = 0; d < ND; d++) begin
            ent.rem[d] = 8'(fval % longint'(ns[d]));
            ent.bc[d]  = 16'((fk < ml[d]) ? fk : ml[d]);
            ent.ov[d]  = ovm[d];
         end
         ent.busy = in_frame;
         ent.rv   = e;
         bq.push_back(ent);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Sends the first nsend bits of a len-bit frame in wire order.
   task automatic send_frame(input longint val, input int len, input int nsend,
                             input bit gap3, input int gap_pct);
      longint v;
      int     idx;
      v = val;
      for (int i = 0; i < nsend; i++) begin
`ifdef MOD_DET_LSB_FIRST_EN
         idx = i;
`else
         idx = len - 1 - i;
`endif
         if ((gap3 && (i % 3 == 2)) || (gap_pct > 0 && $urandom_range(99) < gap_pct))
            send_bit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
         send_bit(1'b1, v[idx], i == 0, i == len - 1);
      end
   endtask

   task automatic apply_reset();
      rst      = 1'b0;
      in_valid = 1'b0;
      x        = 1'b0;
      sof      = 1'b0;
      eof      = 1'b0;
      stim_acc = 1'b0;
      in_frame = 1'b0;
      bq.delete();
      for (int d = 0; d < ND; d++) exp_res[d] = 0;
      #2;
      for (int d = 0; d < ND; d++) begin
         chk_d("rst_rem", d, o_rem[d], 0);
         chk_d("rst_divisible", d, o_div[d], 1);
         chk_d("rst_busy", d, o_busy[d], 0);
         chk_d("rst_result_valid", d, o_rv[d], 0);
         chk_d("rst_result_rem", d, o_rres[d], 0);
         chk_d("rst_bit_count", d, o_bc[d], 0);
         chk_d("rst_overflow", d, o_ov[d], 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic rx_chk(input string nm, input int i, input int d,
                         input int rem, input int bc, input int ov);
      if (rxq.size() > i) begin
         chk_d({nm, "_rem"}, d, rxq[i].rem[d], rem);
         if (bc >= 0) chk_d({nm, "_bit_count"}, d, rxq[i].bc[d], bc);
         if (ov >= 0) chk_d({nm, "_overflow"}, d, rxq[i].ov[d], ov);
      end
   endtask

   // Remember whether the bit sampled at this edge was an accepted one.
   always @(posedge clk or negedge rst) begin
      if (!rst) acc_d <= 1'b0;
      else      acc_d <= stim_acc;
   end

   // Monitor: pop one expectation per accepted bit and compare all DUTs.
   always @(negedge clk) begin
      if (rst) begin
         if (acc_d) begin
            chk("bit_queue_nonempty", bq.size() > 0, 1);
            if (bq.size() > 0) begin
               mon_e = bq.pop_front();
               for (int d = 0; d < ND; d++) begin
                  chk_d("rem", d, o_rem[d], mon_e.rem[d]);
                  chk_d("divisible", d, o_div[d], mon_e.rem[d] == 0);
                  chk_d("bit_count", d, o_bc[d], mon_e.bc[d]);
                  chk_d("overflow", d, o_ov[d], mon_e.ov[d]);
                  chk_d("busy", d, o_busy[d], mon_e.busy);
                  chk_d("result_valid", d, o_rv[d], mon_e.rv);
                  if (mon_e.rv) exp_res[d] = int'(mon_e.rem[d]);
               end
               if (mon_e.rv) begin
                  for (int d = 0; d < ND; d++) begin
                     mon_r.rem[d] = o_rres[d];
                     mon_r.bc[d]  = o_bc[d];
                     mon_r.ov[d]  = o_ov[d];
                  end
                  rxq.push_back(mon_r);
               end
            end
         end else begin
            for (int d = 0; d < ND; d++) chk_d("result_valid_idle", d, o_rv[d], 0);
         end
         for (int d = 0; d < ND; d++) chk_d("result_rem_hold", d, o_rres[d], exp_res[d]);
      end
   end

   initial begin
      longint rv;
      int     len;
      rst      = 1'b1;
      in_valid = 1'b0;
      x        = 1'b0;
      sof      = 1'b0;
      eof      = 1'b0;
      stim_acc = 1'b0;
      in_frame = 1'b0;
      fval     = 0;
      fk       = 0;
      #1;
      apply_reset();

      // Back-to-back frames 147, 148, 149.
      rxq.delete();
      send_frame(147, 8, 8, 1'b0, 0);
      send_frame(148, 8, 8, 1'b0, 0);
      send_frame(149, 8, 8, 1'b0, 0);
      idle(3);
      chk("b2b_result_count", rxq.size(), 3);
      rx_chk("f147", 0, 0, 0, 8, 0);
      rx_chk("f148", 1, 0, 1, 8, 0);
      rx_chk("f149", 2, 0, 2, 8, 0);

      // 48100 with a gap every third cycle.
      rxq.delete();
      send_frame(48100, 16, 16, 1'b1, 0);
      idle(3);
      chk("gap_result_count", rxq.size(), 1);
      rx_chk("f48100", 0, 1, 0, 16, 0);

      // Frame length limit on the MAX_LEN=8 instance.
      rxq.delete();
      send_frame(100, 8, 8, 1'b0, 0);
      idle(2);
      send_frame(300, 9, 9, 1'b0, 0);
      idle(3);
      chk("maxlen_result_count", rxq.size(), 2);
      rx_chk("f100", 0, 2, 2, 8, 0);
      rx_chk("f300", 1, 2, 6, 8, 1);

      // Reset after 5 bits of a 16-bit frame, then a fresh 21.
      rxq.delete();
      send_frame(16'hA5C3, 16, 5, 1'b0, 0);
      @(negedge clk);
      #1;
      apply_reset();
      send_frame(21, 8, 8, 1'b0, 0);
      idle(3);
      chk("reset_result_count", rxq.size(), 1);
      rx_chk("f21", 0, 0, 0, 8, 0);

      // Abort 200 at its fourth bit with a new sof carrying 9.
      rxq.delete();
      send_frame(200, 8, 4, 1'b0, 0);
      send_frame(9, 8, 8, 1'b0, 0);
      idle(3);
      chk("abort_result_count", rxq.size(), 1);
      rx_chk("f9", 0, 0, 0, 8, 0);

      // Random frames: stray bits in IDLE, aborts, one-bit frames, gaps.
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(3) == 0) send_bit(1'b1, 1'($urandom), 1'b0, 1'($urandom));
         if ($urandom_range(4) == 0) begin
            len = $urandom_range(2, 12);
            rv  = longint'($urandom);
            send_frame(rv, len, $urandom_range(1, len - 1), 1'b0, 20);
         end
         len = $urandom_range(1, 20);
         rv  = longint'($urandom);
         send_frame(rv, len, len, 1'b0, 25);
         idle($urandom_range(0, 2));
      end
      idle(4);
      chk("bit_queue_drained", bq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
